// File: rtl/pulse_train_pkg.sv
// Shared types and constants for the pulse train engine.
package pulse_train_pkg;

   typedef enum logic {S_IDLE, S_RUN} state_e;

   localparam int DEF_DEPTH     = 16;
   localparam int DEF_DUR_W     = 8;
   localparam int DEF_CARRIER_W = 16;
   localparam int DEF_PRESC_W   = 4;

   // Symbol word: level sits directly above the duration field.
   function automatic int level_bit(input int dur_w);
      return dur_w;
   endfunction

   localparam int LEVEL_BIT = level_bit(DEF_DUR_W);

endpackage

// File: rtl/pulse_tick_divider.sv
// Power-of-two prescaler: tick once every 2^presc clk, restartable by clear.
module pulse_tick_divider
   import pulse_train_pkg::*;
#(
   parameter int PRESC_W = DEF_PRESC_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick
);

   localparam int CNT_W = 2 ** PRESC_W;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] mask;

   assign mask = (CNT_W'(1) << presc) - CNT_W'(1);
   assign tick = (cnt == mask);

   // Count up, wrap after each tick; clear restarts the period.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) cnt <= '0;
      else if (tick)       cnt <= '0;
      else                 cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/pulse_train_engine.sv
// Symbol-memory driven pulse train generator with looping and optional carrier.
module pulse_train_engine
   import pulse_train_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int DUR_W     = DEF_DUR_W,
   parameter int CARRIER_W = DEF_CARRIER_W,
   parameter int PRESC_W   = DEF_PRESC_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     mem_we,
   input  logic [$clog2(DEPTH)-1:0] mem_addr,
   input  logic [DUR_W:0]           mem_wdata,
   input  logic [$clog2(DEPTH)-1:0] cfg_start_idx,
   input  logic [$clog2(DEPTH)-1:0] cfg_end_idx,
   input  logic [7:0]               cfg_loops,
   input  logic [PRESC_W-1:0]       cfg_presc,
   input  logic [CARRIER_W-1:0]     cfg_carrier_half,
   input  logic                     cfg_carrier_en,
   input  logic                     cfg_idle_level,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     irq_clear,
   output logic                     pulse_out,
   output logic                     busy,
   output logic                     irq
);

   localparam int AW  = $clog2(DEPTH);
   localparam int LVL = level_bit(DUR_W);

   logic [DUR_W:0] mem [DEPTH];

   state_e               state, state_d;
   logic [AW-1:0]        idx, idx_d;
   logic [7:0]           loop_cnt, loop_d;
   logic [DUR_W-1:0]     dur, dur_d, tcnt, tcnt_d;
   logic                 lvl, lvl_d;
   logic                 car, car_d;
   logic [CARRIER_W-1:0] car_cnt, car_cnt_d;
   logic                 started;
   logic                 go, load, irq_set, tick, cen_d, pulse_d;
   logic [DUR_W:0]       sym_rd;

   logic [AW-1:0]        c_start, c_end;
   logic [7:0]           c_loops;
   logic [PRESC_W-1:0]   c_presc;
   logic [CARRIER_W-1:0] c_half;
   logic                 c_cen, c_idle;

   assign go   = (state == S_IDLE) && start && !stop;
   assign busy = (state == S_RUN);

   pulse_tick_divider #(.PRESC_W(PRESC_W)) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (go),
      .presc (c_presc),
      .tick  (tick)
   );

   // Symbol memory: writable any time, never reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   // Configuration snapshot taken on an accepted start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         c_start <= '0; c_end <= '0; c_loops <= '0; c_presc <= '0;
         c_half  <= '0; c_cen <= 1'b0; c_idle <= 1'b0; started <= 1'b0;
      end else if (go) begin
         c_start <= cfg_start_idx; c_end <= cfg_end_idx; c_loops <= cfg_loops;
         c_presc <= cfg_presc; c_half <= cfg_carrier_half;
         c_cen   <= cfg_carrier_en; c_idle <= cfg_idle_level; started <= 1'b1;
      end
   end

   // Sequencing: symbol timing, index advance, looping, carrier and output.
   always_comb begin
      state_d   = state;
      idx_d     = idx;
      loop_d    = loop_cnt;
      tcnt_d    = tcnt;
      load      = 1'b0;
      irq_set   = 1'b0;
      car_d     = car;
      car_cnt_d = car_cnt;
      case (state)
         S_IDLE: if (go) begin
            state_d   = S_RUN;
            idx_d     = cfg_start_idx;
            loop_d    = '0;
            load      = 1'b1;
            car_d     = 1'b1;
            car_cnt_d = '0;
         end
         S_RUN: begin
            if (car_cnt == c_half) begin
               car_d     = ~car;
               car_cnt_d = '0;
            end else begin
               car_cnt_d = car_cnt + CARRIER_W'(1);
            end
            // Stop wins over any symbol advance in the same cycle.
            if (stop) begin
               state_d = S_IDLE;
            end else if (tick) begin
               if (tcnt != dur) begin
                  tcnt_d = tcnt + DUR_W'(1);
               end else if (idx != c_end) begin
                  idx_d = idx + AW'(1);
                  load  = 1'b1;
               end else if (c_loops == 8'd0 ||
                            ({1'b0, loop_cnt} + 9'd1) < {1'b0, c_loops}) begin
                  loop_d = loop_cnt + 8'd1;
                  idx_d  = c_start;
                  load   = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  irq_set = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      sym_rd = mem[idx_d];
      if (load) tcnt_d = '0;
      lvl_d = load ? sym_rd[LVL] : lvl;
      dur_d = load ? sym_rd[DUR_W-1:0] : dur;
      cen_d = go ? cfg_carrier_en : c_cen;
      // Output is computed from next-state values so it lines up with busy.
      if (state_d == S_RUN) pulse_d = lvl_d & (cen_d ? car_d : 1'b1);
      else                  pulse_d = started ? c_idle : cfg_idle_level;
   end

   // Sequencer state registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE; idx <= '0; loop_cnt <= '0; dur <= '0; tcnt <= '0;
         lvl <= 1'b0; car <= 1'b0; car_cnt <= '0; pulse_out <= 1'b0;
      end else begin
         state <= state_d; idx <= idx_d; loop_cnt <= loop_d; dur <= dur_d;
         tcnt <= tcnt_d; lvl <= lvl_d; car <= car_d; car_cnt <= car_cnt_d;
         pulse_out <= pulse_d;
      end
   end

   // Sticky completion flag; a completion beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!rst_n)         irq <= 1'b0;
      else if (irq_set)   irq <= 1'b1;
      else if (irq_clear) irq <= 1'b0;
   end

endmodule

// File: tb/tb_pulse_train_engine.sv
// Randomized and directed checks of pulse_train_engine against a waveform model.
module tb_pulse_train_engine;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       mem_we;
   logic [3:0] mem_addr;
   logic [8:0] mem_wdata;
   logic [3:0] cfg_start_idx, cfg_end_idx;
   logic [7:0] cfg_loops;
   logic [3:0] cfg_presc;
   logic [15:0] cfg_carrier_half;
   logic       cfg_carrier_en, cfg_idle_level;
   logic       start, stop, irq_clear;
   logic       pulse_out, busy, irq;

   int checks   = 0;
   int failures = 0;

   logic [8:0] smem [16];
   logic       exp_q [$];

   always #5 clk = ~clk;

   pulse_train_engine dut (
      .clk(clk), .rst_n(rst_n), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .cfg_start_idx(cfg_start_idx),
      .cfg_end_idx(cfg_end_idx), .cfg_loops(cfg_loops), .cfg_presc(cfg_presc),
      .cfg_carrier_half(cfg_carrier_half), .cfg_carrier_en(cfg_carrier_en),
      .cfg_idle_level(cfg_idle_level), .start(start), .stop(stop),
      .irq_clear(irq_clear), .pulse_out(pulse_out), .busy(busy), .irq(irq)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic lvl, input int d);
      smem[a]   = {lvl, 8'(d)};
      mem_we    = 1'b1;
      mem_addr  = 4'(a);
      mem_wdata = {lvl, 8'(d)};
      step();
      mem_we    = 1'b0;
   endtask

   task automatic set_cfg(input int s, input int e, input int lp, input int pr,
                          input int half, input logic cen, input logic idle);
      cfg_start_idx    = 4'(s);
      cfg_end_idx      = 4'(e);
      cfg_loops        = 8'(lp);
      cfg_presc        = 4'(pr);
      cfg_carrier_half = 16'(half);
      cfg_carrier_en   = cen;
      cfg_idle_level   = idle;
   endtask

   // Expected RUN waveform: each symbol is (d+1)*2^presc clk of its level,
   // programs repeat lp times, carrier is a square wave of period 2*(half+1).
   task automatic build_exp(input int s, input int e, input int lp, input int pr,
                            input int half, input logic cen);
      int idx, dur;
      bit done;
      exp_q.delete();
      for (int l = 0; l < lp; l++) begin
         idx  = s;
         done = 0;
         while (!done) begin
            dur = (int'(smem[idx][7:0]) + 1) << pr;
            for (int c = 0; c < dur; c++) exp_q.push_back(smem[idx][8]);
            if (idx == e) done = 1;
            else idx = (idx + 1) % 16;
         end
      end
      if (cen)
         for (int k = 0; k < exp_q.size(); k++)
            if (((k / (half + 1)) % 2) == 1) exp_q[k] = 1'b0;
   endtask

   // Start a program, compare every RUN cycle, then the completion state.
   task automatic run_check(input string nm, input int s, input int e,
                            input int lp, input int pr, input int half,
                            input logic cen, input logic idle,
                            input bit scramble, input bit clr_last);
      int n;
      build_exp(s, e, lp, pr, half, cen);
      n = exp_q.size();
      irq_clear = 1'b1; step(); irq_clear = 1'b0;
      set_cfg(s, e, lp, pr, half, cen, idle);
      start = 1'b1; step(); start = 1'b0;
      for (int k = 0; k < n; k++) begin
         checks++;
         if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy k=%0d got=%b exp=1", nm, k, busy);
         end
         checks++;
         if (pulse_out !== exp_q[k]) begin
            failures++;
            $display("FAIL %s pulse k=%0d got=%b exp=%b", nm, k, pulse_out, exp_q[k]);
         end
         if (scramble && k < n - 1) begin
            set_cfg($urandom_range(15), $urandom_range(15), $urandom_range(255),
                    $urandom_range(15), $urandom_range(7), 1'($urandom),
                    1'($urandom));
            start = 1'($urandom);
         end else begin
            start = 1'b0;
         end
         irq_clear = clr_last && (k == n - 1);
         step();
         irq_clear = 1'b0;
      end
      checks++;
      if (busy !== 1'b0 || irq !== 1'b1 || pulse_out !== idle) begin
         failures++;
         $display("FAIL %s done busy/irq/pulse got=%b%b%b exp=01%b",
                  nm, busy, irq, pulse_out, idle);
      end
      if (clr_last) begin
         irq_clear = 1'b1; step(); irq_clear = 1'b0;
         checks++;
         if (irq !== 1'b0) begin
            failures++;
            $display("FAIL %s irq_clear got=%b exp=0", nm, irq);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cfg_idle_level = 1'b1;
      step(); step();
      checks++;
      if (busy !== 1'b0 || irq !== 1'b0 || pulse_out !== 1'b0) begin
         failures++;
         $display("FAIL reset busy/irq/pulse got=%b%b%b exp=000", busy, irq, pulse_out);
      end
      rst_n = 1'b1; step();
      checks++;
      if (pulse_out !== 1'b1) begin
         failures++;
         $display("FAIL reset_live_idle got=%b exp=1", pulse_out);
      end
      cfg_idle_level = 1'b0; step();
      checks++;
      if (pulse_out !== 1'b0) begin
         failures++;
         $display("FAIL reset_live_idle0 got=%b exp=0", pulse_out);
      end
   endtask

   task automatic test_directed();
      wr(0, 1'b1, 3); wr(1, 1'b0, 1);
      run_check("basic", 0, 1, 1, 0, 0, 1'b0, 1'b0, 0, 0);
      wr(2, 1'b1, 0);
      run_check("presc_loops", 2, 2, 3, 2, 0, 1'b0, 1'b0, 0, 0);
      wr(3, 1'b1, 7); wr(4, 1'b0, 5);
      run_check("carrier", 3, 4, 1, 0, 1, 1'b1, 1'b1, 0, 0);
      wr(14, 1'b1, 0); wr(15, 1'b0, 1); wr(0, 1'b1, 2); wr(1, 1'b0, 3);
      run_check("wrap", 14, 1, 1, 0, 0, 1'b0, 1'b1, 0, 0);
   endtask

   task automatic test_irq_clear();
      wr(5, 1'b1, 1);
      run_check("irq_race", 5, 5, 1, 0, 0, 1'b0, 1'b0, 0, 1);
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         for (int a = 0; a < 16; a++) wr(a, 1'($urandom), $urandom_range(3));
         run_check("random", $urandom_range(15), $urandom_range(15),
                   $urandom_range(1, 2), $urandom_range(2), $urandom_range(3),
                   1'($urandom), 1'($urandom), 1, 0);
      end
   endtask

   task automatic test_stop();
      wr(0, 1'b1, 2); wr(1, 1'b0, 2);
      irq_clear = 1'b1; step(); irq_clear = 1'b0;
      set_cfg(0, 1, 0, 0, 0, 1'b0, 1'b1);
      start = 1'b1; step(); start = 1'b0;
      repeat (20) step();
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL stop_infinite busy got=%b exp=1", busy);
      end
      stop = 1'b1; step(); stop = 1'b0;
      checks++;
      if (busy !== 1'b0 || pulse_out !== 1'b1 || irq !== 1'b0) begin
         failures++;
         $display("FAIL stop busy/pulse/irq got=%b%b%b exp=010", busy, pulse_out, irq);
      end
      start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL start_stop_idle busy got=%b exp=0", busy);
      end
   endtask

   // Rewriting the running symbol affects only its next load.
   task automatic test_mem_rewrite();
      logic ex [6];
      ex = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      wr(3, 1'b1, 3);
      irq_clear = 1'b1; step(); irq_clear = 1'b0;
      set_cfg(3, 3, 2, 0, 0, 1'b0, 1'b0);
      start = 1'b1; step(); start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (pulse_out !== ex[k] || busy !== 1'b1) begin
            failures++;
            $display("FAIL rewrite k=%0d pulse/busy got=%b%b exp=%b1", k, pulse_out, busy, ex[k]);
         end
         if (k == 0) begin
            mem_we = 1'b1; mem_addr = 4'd3; mem_wdata = {1'b0, 8'd1};
         end
         step();
         mem_we = 1'b0;
      end
      checks++;
      if (busy !== 1'b0 || irq !== 1'b1) begin
         failures++;
         $display("FAIL rewrite_done busy/irq got=%b%b exp=01", busy, irq);
      end
      smem[3] = {1'b0, 8'd1};
   endtask

   task automatic test_reset_midrun();
      irq_clear = 1'b1; step(); irq_clear = 1'b0;
      set_cfg(0, 1, 0, 0, 0, 1'b0, 1'b1);
      start = 1'b1; step(); start = 1'b0;
      repeat (5) step();
      rst_n = 1'b0; step(); rst_n = 1'b1;
      checks++;
      if (busy !== 1'b0 || irq !== 1'b0 || pulse_out !== 1'b0) begin
         failures++;
         $display("FAIL reset_midrun busy/irq/pulse got=%b%b%b exp=000", busy, irq, pulse_out);
      end
   endtask

   initial begin
      rst_n = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
      start = 1'b0; stop = 1'b0; irq_clear = 1'b0;
      set_cfg(0, 0, 1, 0, 0, 1'b0, 1'b0);
      test_reset();
      test_directed();
      test_irq_clear();
      test_random();
      test_stop();
      test_mem_rewrite();
      test_reset_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pulse_train_engine.md
PULSE_TRAIN_ENGINE -- requirements
Module: pulse_train_engine

Interface
REQ-001 Parameter DEPTH, default 16: number of symbol memory entries, a power of two, at least 2.
REQ-002 Parameter DUR_W, default 8: symbol duration field width.
REQ-003 Parameter CARRIER_W, default 16: carrier half-period count width.
REQ-004 Parameter PRESC_W, default 4: prescaler exponent width.
REQ-005 clk  in  1  clock; all logic on posedge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 mem_we  in  1  symbol memory write strobe.
REQ-008 mem_addr  in  clog2(DEPTH)  symbol write index.
REQ-009 mem_wdata  in  DUR_W+1  symbol word: [DUR_W] is the level; [DUR_W-1:0] is duration d.
REQ-010 cfg_start_idx, cfg_end_idx  in  clog2(DEPTH) each  first and last symbol of the program.
REQ-011 cfg_loops  in  8  program repetitions; 0 means infinite.
REQ-012 cfg_presc  in  PRESC_W  tick period of 2^cfg_presc clk.
REQ-013 cfg_carrier_half  in  CARRIER_W  carrier half-period of cfg_carrier_half+1 clk.
REQ-014 cfg_carrier_en, cfg_idle_level  in  1 each  carrier enable; output level when idle.
REQ-015 start, stop, irq_clear  in  1 each  single-cycle command strobes.
REQ-016 pulse_out  out  1  modulated output.
REQ-017 busy  out  1  high while in RUN.
REQ-018 irq  out  1  sticky completion flag.

Function
REQ-019 Two states: IDLE and RUN.
REQ-020 In IDLE, start (with stop low) latches all cfg_* inputs, sets idx to the latched start index and the loop count to 0, loads the symbol at that index, resets the prescaler and carrier, and enters RUN next cycle.
REQ-021 Symbol memory read is combinational; a loaded symbol lasts exactly d+1 ticks, with no gap cycles between symbols.
REQ-022 Tick = prescaler counter equal to 2^presc-1; the counter wraps to 0 after a tick; presc=0 gives a tick every clk.
REQ-023 Symbol end, when idx differs from end index: idx <= (idx+1) mod DEPTH, then load that symbol; end index below start index therefore wraps through DEPTH-1 to 0.
REQ-024 Symbol end, when idx equals end index: if loops=0, or loop count+1 is less than loops, increment the loop count, set idx to the start index and load; otherwise go to IDLE and set irq.
REQ-025 pulse_out in IDLE = latched idle level (live cfg_idle_level before the first start).
REQ-026 pulse_out in RUN = level AND carrier when carrier enabled, otherwise level; pulse_out is registered.
REQ-027 Carrier starts at 1 on the cycle RUN is entered, then toggles every cfg_carrier_half+1 clk, free-running across symbols.
REQ-028 Stop in RUN: enter IDLE next cycle, irq not set; stop has priority over symbol advance.
REQ-029 Start while in RUN is ignored; stop and start together in IDLE: no start.
REQ-030 irq is set on completion and cleared by irq_clear; set wins when both occur in the same cycle.
REQ-031 mem_we is accepted in any state; an entry rewritten during RUN takes effect at its next load.
REQ-032 Changes to cfg_* during RUN have no effect until the next start.

Reset
REQ-033 rst_n low: state IDLE, busy 0, irq 0, pulse_out 0, all counters 0, latched config 0; symbol memory is not reset.
REQ-034 Reset mid-RUN aborts the program without setting irq.

Structure
REQ-035 Shared package pulse_train_pkg holds the state enum, the symbol field positions (LEVEL_BIT) and the default parameter constants.
REQ-036 The prescaler tick generator is the sub-module pulse_tick_divider: inputs clk, rst_n, clear, presc; output tick.

Verification
REQ-037 presc=0, carrier off, mem[0]={1,3}, mem[1]={0,1}, start=0, end=1, loops=1 -> pulse_out high 4 clk, then low 2 clk, then irq=1 and busy=0.
REQ-038 presc=2, mem[2]={1,0}, start=end=2, loops=3 -> three 4-clk high pulses back to back, busy for 12 clk, irq once.
REQ-039 Carrier on, half=1, symbol {1,7}, presc=0 -> pulse_out 1100 repeated over 8 clk; a {0,x} symbol gives constant 0.
REQ-040 DEPTH=16, start=14, end=1 -> visit order 14, 15, 0, 1.
REQ-041 loops=0, stop asserted after 20 clk -> IDLE next cycle, pulse_out = idle level, irq stays 0.
REQ-042 irq_clear in the same cycle as completion -> irq=1; irq_clear one cycle later -> irq=0.
